id_stage_pipe: RTL and testbench

- Parametrised successor of the ARM decode stage.
- Decodes the IF/ID instruction, reads a parametrised register file with write-through bypass from WB, and evaluates the condition field.
- Detects RAW hazards against EX/MEM internally and drives the IF freeze.
- Registers every decode result into an integrated ID/EX pipeline register with valid, stall-bubble and flush.

---
 rtl/id_stage_pipe.sv | 179 +++++++++++++++++
 tb/tb_id_stage_pipe.sv | 139 +++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: ARM-style decode stage with integrated ID/EX pipeline register.
// Decodes the IF/ID instruction, evaluates its condition against SR, reads a
// 2**REG_ADDR_W entry register file with write-through bypass from WB, detects
// RAW hazards against EX/MEM (combinational hazard output freezes PC and IF/ID)
// and registers the results into ID/EX with valid, bubble and flush handling.
// Ports:
//   clk, rst (async, active-low)
//   IF/ID : instr_in, pc_in, valid_in      status : SR {N,Z,C,V}
//   control: flush (kill ID/EX), hazard (out, combinational freeze)
//   WB    : wb_en, wb_dest, wb_value
//   EX/MEM: exe_dest, mem_dest, exe_wb_en, mem_wb_en, exe_mem_r_en
//   ID/EX : valid_out, EXE_CMD, WB_EN, MEM_R_EN, MEM_W_EN, B, S, Val_Rn, Val_Rm,
//           imm, Shift_operand, Signed_imm_24, Dest, src1, src2, pc_out
// Build option: define FORWARD_EN when EX forwards operands, so only a
// load-use dependency on the EX stage raises hazard.
module id_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int PC_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr_in,
  input  logic [PC_W-1:0]       pc_in,
  input  logic                  valid_in,
  input  logic [3:0]            SR,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]     wb_value,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  exe_wb_en,
  input  logic                  mem_wb_en,
  input  logic                  exe_mem_r_en,
  output logic                  hazard,
  output logic                  valid_out,
  output logic [3:0]            EXE_CMD,
  output logic                  WB_EN,
  output logic                  MEM_R_EN,
  output logic                  MEM_W_EN,
  output logic                  B,
  output logic                  S,
  output logic [DATA_W-1:0]     Val_Rn,
  output logic [DATA_W-1:0]     Val_Rm,
  output logic                  imm,
  output logic [11:0]           Shift_operand,
  output logic [23:0]           Signed_imm_24,
  output logic [REG_ADDR_W-1:0] Dest,
  output logic [REG_ADDR_W-1:0] src1,
  output logic [REG_ADDR_W-1:0] src2,
  output logic [PC_W-1:0]       pc_out
);
  localparam int NREG = 2 ** REG_ADDR_W;
  logic [DATA_W-1:0] rf [NREG];
  logic n, z, c, v, cond_ok;
  logic [1:0] mode;
  logic [3:0] opc, dp_cmd;
  logic is_nop, is_dp, is_mem, is_br, is_str, is_imm, two_src, dp_wb;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic [DATA_W-1:0] rn_val, rm_val;
  logic [3:0] d_cmd;
  logic d_wb, d_mr, d_mw, d_b, d_s, hit1, hit2, kill;
  assign {n, z, c, v} = SR;
  always_comb begin
    case (instr_in[31:28])
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = ~z;
      4'b0010: cond_ok = c;
      4'b0011: cond_ok = ~c;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = ~n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = ~v;
      4'b1000: cond_ok = c & ~z;
      4'b1001: cond_ok = ~c | z;
      4'b1010: cond_ok = n == v;
      4'b1011: cond_ok = n != v;
      4'b1100: cond_ok = ~z & (n == v);
      4'b1101: cond_ok = z | (n != v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
  assign mode   = instr_in[27:26];
  assign opc    = instr_in[24:21];
  assign is_nop = instr_in == 32'd0;
  assign is_dp  = mode == 2'b00 && !is_nop;
  assign is_mem = mode == 2'b01;
  assign is_br  = mode == 2'b10;
  assign is_str = is_mem & ~instr_in[20];
  assign is_imm = instr_in[25];
  assign two_src = ~is_imm | is_str;
  always_comb begin
    case (opc)
      4'b1101: dp_cmd = 4'b0001;
      4'b1111: dp_cmd = 4'b1001;
      4'b0100: dp_cmd = 4'b0010;
      4'b0101: dp_cmd = 4'b0011;
      4'b0010: dp_cmd = 4'b0100;
      4'b0110: dp_cmd = 4'b0101;
      4'b0000: dp_cmd = 4'b0110;
      4'b1100: dp_cmd = 4'b0111;
      4'b0001: dp_cmd = 4'b1000;
      4'b1010: dp_cmd = 4'b0100;
      4'b1000: dp_cmd = 4'b0110;
      default: dp_cmd = 4'b0000;
    endcase
  end
  // every recognised opcode has a non-zero command; CMP/TST only set flags
  assign dp_wb = dp_cmd != 4'b0000 && opc != 4'b1010 && opc != 4'b1000;
  assign d_cmd = is_dp ? dp_cmd : is_mem ? 4'b0010 : 4'b0000;
  assign d_wb  = (is_dp & dp_wb) | (is_mem & instr_in[20]);
  assign d_mr  = is_mem & instr_in[20];
  assign d_mw  = is_str;
  assign d_b   = is_br;
  assign d_s   = is_dp & instr_in[20];
  assign rs1 = REG_ADDR_W'(instr_in[19:16]);
  assign rs2 = is_str ? REG_ADDR_W'(instr_in[15:12]) : REG_ADDR_W'(instr_in[3:0]);
  assign rd  = REG_ADDR_W'(instr_in[15:12]);
  assign rn_val = (wb_en && wb_dest == rs1) ? wb_value : rf[rs1];
  assign rm_val = (wb_en && wb_dest == rs2) ? wb_value : rf[rs2];
`ifdef FORWARD_EN
  assign hit1 = exe_wb_en & exe_mem_r_en & (rs1 == exe_dest);
  assign hit2 = exe_wb_en & exe_mem_r_en & (rs2 == exe_dest);
`else
  assign hit1 = (exe_wb_en & (rs1 == exe_dest)) | (mem_wb_en & (rs1 == mem_dest));
  assign hit2 = (exe_wb_en & (rs2 == exe_dest)) | (mem_wb_en & (rs2 == mem_dest));
`endif
  assign hazard = valid_in & ~is_br & ~is_nop & (hit1 | (two_src & hit2));
  assign kill = flush | hazard | ~valid_in | ~cond_ok;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= DATA_W'(i);
    end else if (wb_en) begin
      rf[wb_dest] <= wb_value;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out     <= 1'b0;
      EXE_CMD       <= 4'b0;
      WB_EN         <= 1'b0;
      MEM_R_EN      <= 1'b0;
      MEM_W_EN      <= 1'b0;
      B             <= 1'b0;
      S             <= 1'b0;
      Val_Rn        <= '0;
      Val_Rm        <= '0;
      imm           <= 1'b0;
      Shift_operand <= 12'b0;
      Signed_imm_24 <= 24'b0;
      Dest          <= '0;
      src1          <= '0;
      src2          <= '0;
      pc_out        <= '0;
    end else begin
      valid_out <= valid_in & ~flush & ~hazard;
      EXE_CMD   <= kill ? 4'b0 : d_cmd;
      WB_EN     <= ~kill & d_wb;
      MEM_R_EN  <= ~kill & d_mr;
      MEM_W_EN  <= ~kill & d_mw;
      B         <= ~kill & d_b;
      S         <= ~kill & d_s;
      // data fields follow the slot even through bubbles; only flush holds them
      if (!flush) begin
        Val_Rn        <= rn_val;
        Val_Rm        <= rm_val;
        imm           <= is_imm;
        Shift_operand <= instr_in[11:0];
        Signed_imm_24 <= instr_in[23:0];
        Dest          <= rd;
        src1          <= rs1;
        src2          <= rs2;
        pc_out        <= pc_in;
      end
    end
  end
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed checks of id_stage_pipe decode, regfile, hazard and ID/EX register.
module tb_id_stage_pipe;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] instr_in = 32'd0, pc_in = 32'd0, wb_value = 32'd0;
  logic valid_in = 1'b0, flush = 1'b0, wb_en = 1'b0;
  logic [3:0] SR = 4'd0, wb_dest = 4'd0, exe_dest = 4'd0, mem_dest = 4'd0;
  logic exe_wb_en = 1'b0, mem_wb_en = 1'b0, exe_mem_r_en = 1'b0;
  logic hazard, valid_out, WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm;
  logic [3:0] EXE_CMD, Dest, src1, src2;
  logic [31:0] Val_Rn, Val_Rm, pc_out;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  int total = 0, bad = 0;
  logic fwd;
  id_stage_pipe dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .valid_in(valid_in),
    .SR(SR), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .hazard(hazard), .valid_out(valid_out), .EXE_CMD(EXE_CMD),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .B(B), .S(S),
    .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm), .Shift_operand(Shift_operand),
    .Signed_imm_24(Signed_imm_24), .Dest(Dest), .src1(src1), .src2(src2), .pc_out(pc_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
`ifdef FORWARD_EN
    fwd = 1'b1;
`else
    fwd = 1'b0;
`endif
    #2;
    chk("rst_valid", valid_out, 0);
    chk("rst_cmd", EXE_CMD, 0);
    chk("rst_vrn", Val_Rn, 0);
    #10 rst = 1'b1;
    instr_in = 32'hE0850006;
    step();
    chk("init_vrn", Val_Rn, 5);
    chk("init_vrm", Val_Rm, 6);
    chk("init_wb", WB_EN, 0);
    chk("init_cmd", EXE_CMD, 0);
    chk("init_valid", valid_out, 0);
    instr_in = 32'hE0821003; valid_in = 1'b1; pc_in = 32'h100;
    #1 chk("add_haz", hazard, 0);
    step();
    chk("add_cmd", EXE_CMD, 4'b0010);
    chk("add_wb", WB_EN, 1);
    chk("add_src1", src1, 2);
    chk("add_src2", src2, 3);
    chk("add_dest", Dest, 1);
    chk("add_valid", valid_out, 1);
    chk("add_pc", pc_out, 32'h100);
    chk("add_vrm", Val_Rm, 3);
    wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'hDEADBEEF;
    step();
    chk("wt_vrn", Val_Rn, 32'hDEADBEEF);
    wb_en = 1'b0;
    step();
    chk("rf_hold", Val_Rn, 32'hDEADBEEF);
    exe_dest = 4'd2; exe_wb_en = 1'b1;
    #1 chk("exe_haz", hazard, !fwd);
    step();
    chk("exe_valid", valid_out, fwd);
    chk("exe_wb", WB_EN, fwd);
    exe_mem_r_en = 1'b1;
    #1 chk("ld_haz", hazard, 1);
    step();
    chk("ld_valid", valid_out, 0);
    chk("ld_cmd", EXE_CMD, 0);
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_dest = 4'd3; mem_wb_en = 1'b1;
    #1 chk("mem_haz", hazard, !fwd);
    instr_in = 32'hE2821003;
    #1 chk("imm_nohaz", hazard, 0);
    mem_wb_en = 1'b0;
    instr_in = 32'h00821003; SR = 4'b0000;
    step();
    chk("eq_f_valid", valid_out, 1);
    chk("eq_f_wb", WB_EN, 0);
    SR = 4'b0100;
    step();
    chk("eq_t_wb", WB_EN, 1);
    chk("eq_t_cmd", EXE_CMD, 4'b0010);
    instr_in = 32'hF0821003;
    step();
    chk("nv_wb", WB_EN, 0);
    instr_in = 32'hE5921004;
    step();
    chk("ldr_cmd", EXE_CMD, 4'b0010);
    chk("ldr_wb", WB_EN, 1);
    chk("ldr_mr", MEM_R_EN, 1);
    chk("ldr_s", S, 0);
    instr_in = 32'hE5821004;
    step();
    chk("str_mw", MEM_W_EN, 1);
    chk("str_wb", WB_EN, 0);
    chk("str_src2", src2, 1);
    chk("str_vrm", Val_Rm, 1);
    instr_in = 32'hE1520003;
    step();
    chk("cmp_cmd", EXE_CMD, 4'b0100);
    chk("cmp_wb", WB_EN, 0);
    chk("cmp_s", S, 1);
    instr_in = 32'hEA000010; exe_dest = 4'd0; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    #1 chk("br_nohaz", hazard, 0);
    step();
    chk("br_b", B, 1);
    chk("br_cmd", EXE_CMD, 0);
    chk("br_imm24", Signed_imm_24, 24'h000010);
    instr_in = 32'hE0821003; exe_dest = 4'd2; flush = 1'b1; pc_in = 32'h200;
    #1 chk("fl_haz", hazard, 1);
    step();
    chk("fl_valid", valid_out, 0);
    chk("fl_wb", WB_EN, 0);
    chk("fl_hold_pc", pc_out, 32'h100);
    flush = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    step();
    chk("pre_rst_valid", valid_out, 1);
    #2 rst = 1'b0;
    #1 chk("arst_valid", valid_out, 0);
    chk("arst_wb", WB_EN, 0);
    chk("arst_cmd", EXE_CMD, 0);
    rst = 1'b1;
    step();
    chk("rf_reinit", Val_Rn, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
